hit_detector: RTL

Per-object collision detector feeding the HP bar. Each pixel clock it tests the player heart's bounding box against the boxes of bullet 1, bullet 2, the big attack and the green heal orb. It drives registered collision levels and one-cycle damage/heal event pulses. It also enforces a frame-counted invulnerability window, so one hit on the heart cannot drain HP on consecutive frames.

---
 rtl/hit_detector.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/hit_detector.sv
// hit_detector: per-object collision detector for the HP bar.
//
// Each Pclk cycle the heart's bounding box is tested against bullet 1, bullet 2,
// the big attack and the heal orb. Registered collision levels are produced, and
// their rising edges generate one-cycle damage and heal pulses.
//
// Optional feature macro: HIT_INVULN_EN. When defined, a damage event opens an
// invulnerability window that lasts INVULN_FRAMES frame ticks. During the window,
// further damage edges are dropped. When undefined, every damage edge pulses and
// invuln is tied low.
//
// Ports:
//   Pclk, rst_n        pixel clock, asynchronous active-low reset
//   frame_tick         one-cycle pulse per video frame
//   state_game         game state; 1 = new attack round (clears edges/heal/FSM)
//   heart_x/y          heart top-left
//   b1/b2/big/gb_x/y   object top-left positions
//   obj_en             object present flags {GB, Big, B2, B1}
//   isCollision*       registered overlap levels
//   dmg_pulse/dmg_amt  one-cycle damage event and its amount (60 Big, else 30)
//   heal_pulse         one-cycle heal event, at most once per round
//   invuln             high while invulnerable
module hit_detector #(
  parameter int unsigned HEART_W       = 16,
  parameter int unsigned BUL_W         = 16,
  parameter int unsigned BIG_W         = 64,
  parameter int unsigned GB_W          = 16,
  parameter int unsigned INVULN_FRAMES = 30
) (
  input  logic       Pclk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic [1:0] state_game,
  input  logic [9:0] heart_x,
  input  logic [9:0] heart_y,
  input  logic [9:0] b1_x,
  input  logic [9:0] b1_y,
  input  logic [9:0] b2_x,
  input  logic [9:0] b2_y,
  input  logic [9:0] big_x,
  input  logic [9:0] big_y,
  input  logic [9:0] gb_x,
  input  logic [9:0] gb_y,
  input  logic [3:0] obj_en,
  output logic       isCollisionB1,
  output logic       isCollisionB2,
  output logic       isCollisionBig,
  output logic       isCollisionGB,
  output logic       dmg_pulse,
  output logic [6:0] dmg_amt,
  output logic       heal_pulse,
  output logic       invuln
);

  localparam logic [10:0] HeartW = 11'(HEART_W);
  localparam logic [10:0] BulW   = 11'(BUL_W);
  localparam logic [10:0] BigW   = 11'(BIG_W);
  localparam logic [10:0] GbW    = 11'(GB_W);
  localparam logic [7:0]  InvInit = 8'(INVULN_FRAMES);

  // Half-open axis-aligned overlap. The sums are 11 bits wide, so a box near
  // the 1023 edge does not wrap around to 0.
  function automatic logic overlap(input logic [9:0] hx, input logic [9:0] hy,
                                   input logic [9:0] ox, input logic [9:0] oy,
                                   input logic [10:0] w);
    logic [10:0] hx_e, hy_e, ox_e, oy_e;
    hx_e = {1'b0, hx};
    hy_e = {1'b0, hy};
    ox_e = {1'b0, ox};
    oy_e = {1'b0, oy};
    return (hx_e < ox_e + w) && (ox_e < hx_e + HeartW) &&
           (hy_e < oy_e + w) && (oy_e < hy_e + HeartW);
  endfunction

  logic [3:0] coll_d, coll_q, prev_q, rise;
  logic       round;
  logic       dmg_rise, dmg_fire, heal_fire;
  logic       dmg_pulse_q, heal_pulse_q, heal_used_q;
  logic [6:0] dmg_amt_q;

  assign round = (state_game == 2'd1);

  always_comb begin
    coll_d    = '0;
    coll_d[0] = obj_en[0] & overlap(heart_x, heart_y, b1_x, b1_y, BulW);
    coll_d[1] = obj_en[1] & overlap(heart_x, heart_y, b2_x, b2_y, BulW);
    coll_d[2] = obj_en[2] & overlap(heart_x, heart_y, big_x, big_y, BigW);
    coll_d[3] = obj_en[3] & overlap(heart_x, heart_y, gb_x, gb_y, GbW);
  end

  // Edges are suppressed while a round is starting. The previous-value
  // registers are held at 0 then, so an overlap that persists across the round
  // start produces a fresh edge once state_game leaves 1.
  assign rise      = coll_q & ~prev_q & {4{~round}};
  assign dmg_rise  = |rise[2:0];
  assign heal_fire = rise[3] & ~heal_used_q;

`ifdef HIT_INVULN_EN
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] INVULN = 1'b1;

  logic [0:0] state_d, state_q;
  logic [7:0] cnt_d, cnt_q;

  assign dmg_fire = dmg_rise & (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (dmg_rise) begin
          state_d = INVULN;
          cnt_d   = InvInit;
        end
      end
      INVULN: begin
        if (round) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == 8'd0) begin
          state_d = IDLE;
        end else if (frame_tick && !dmg_pulse_q) begin
          // A tick coincident with the entering pulse does not count.
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge Pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign invuln = (state_q == INVULN);
`else
  logic unused_cfg;

  assign dmg_fire   = dmg_rise;
  assign invuln     = 1'b0;
  assign unused_cfg = ^{frame_tick, InvInit};
`endif

  always_ff @(posedge Pclk or negedge rst_n) begin
    if (!rst_n) begin
      coll_q       <= '0;
      prev_q       <= '0;
      dmg_pulse_q  <= 1'b0;
      dmg_amt_q    <= '0;
      heal_pulse_q <= 1'b0;
      heal_used_q  <= 1'b0;
    end else begin
      coll_q       <= coll_d;
      prev_q       <= round ? 4'b0000 : coll_q;
      dmg_pulse_q  <= dmg_fire;
      // Big has priority and amounts never sum.
      dmg_amt_q    <= dmg_fire ? (rise[2] ? 7'd60 : 7'd30) : 7'd0;
      heal_pulse_q <= heal_fire;
      heal_used_q  <= round ? 1'b0 : (heal_used_q | heal_fire);
    end
  end

  assign isCollisionB1  = coll_q[0];
  assign isCollisionB2  = coll_q[1];
  assign isCollisionBig = coll_q[2];
  assign isCollisionGB  = coll_q[3];
  assign dmg_pulse      = dmg_pulse_q;
  assign dmg_amt        = dmg_amt_q;
  assign heal_pulse     = heal_pulse_q;

endmodule
